axil_mem_responder: RTL and testbench
=====================================

Name: axil_mem_responder

Overview:
AXI4-Lite subordinate (responder) end. It accepts read and write transactions from an AXI4-Lite manager and replays them, one at a time, onto the team's single-port SimpleMemory-style request/response interface. It is the counterpart of the memory-to-AXI initiator adapter: the manager adapter drives the AXI bus, and this block terminates it in front of a memory model or RAM.

Parameters:
ADDR_W, 32, address width on both AXI and memory sides (byte address)
DATA_W, 32, data width; must be 32 or 64
ADDR_BASE, 0, lowest decoded byte address (used only with the optional feature)
ADDR_SIZE, 4096, decoded window size in bytes (used only with the optional feature)

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  reset, asynchronous, active-high
s_awvalid_i / s_awready_o  in/out  1  AW handshake
s_awaddr_i  in  ADDR_W  write address
s_awprot_i  in  3  accepted and ignored
s_wvalid_i / s_wready_o  in/out  1  W handshake
s_wdata_i  in  DATA_W  write data
s_wstrb_i  in  DATA_W/8  byte strobes
s_bvalid_o / s_bready_i  out/in  1  B handshake
s_bresp_o  out  2  write response
s_arvalid_i / s_arready_o  in/out  1  AR handshake
s_araddr_i  in  ADDR_W  read address
s_arprot_i  in  3  accepted and ignored
s_rvalid_o / s_rready_i  out/in  1  R handshake
s_rdata_o  out  DATA_W  read data
s_rresp_o  out  2  read response
mem_valid_o / mem_ready_i  out/in  1  memory request handshake
mem_we_o  out  1  1 = write, 0 = read
mem_addr_o  out  ADDR_W  request address, passed through unmodified
mem_wdata_o  out  DATA_W  write data
mem_wstrb_o  out  DATA_W/8  byte strobes; all-zero on reads
mem_rvalid_i  in  1  one-cycle response pulse, exactly one per accepted request
mem_rdata_i  in  DATA_W  read data, valid with mem_rvalid_i
mem_err_i  in  1  response error, valid with mem_rvalid_i

Behaviour:
- Reset (asynchronous, active-high): all valid/ready outputs 0; all data, address, strobe and resp outputs 0; buffers empty; state IDLE; priority pointer set to write.
- Reset asserted mid-transaction: the transaction is dropped with no B or R response. The memory shares the same reset, so no stale mem_rvalid_i follows.
- AW and W each have a one-entry register. s_awready_o = AW register empty; s_wready_o = W register empty. AW and W are accepted independently and in either order.
- AR has a one-entry register. s_arready_o = AR register empty.
- A write is pending when both AW and W registers are full. A read is pending when the AR register is full.
- Only one transaction is in flight at a time (no AXI outstanding beyond the buffers).
- FSM states: IDLE, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_RESP.
  - IDLE -> WR_REQ when a write is pending; IDLE -> RD_REQ when a read is pending.
  - If both are pending, round-robin decides, with write winning first after reset. The pointer toggles after each granted transaction.
  - WR_REQ / RD_REQ: mem_valid_o = 1. Address, data and strobes are held stable until mem_ready_i; then go to WR_WAIT / RD_WAIT.
  - On acceptance, the consumed buffers are freed at that edge.
  - WR_WAIT / RD_WAIT: on mem_rvalid_i, capture the response and go to WR_RESP / RD_RESP.
  - mem_rvalid_i arrives at least 1 cycle after the accept edge. A mem_rvalid_i seen in any other state is ignored.
  - WR_RESP: s_bvalid_o = 1 until s_bready_i, then IDLE. RD_RESP: s_rvalid_o = 1 with captured data until s_rready_i, then IDLE. Response payloads are held stable while valid.
- Response code: 2'b00 OKAY; 2'b10 SLVERR if mem_err_i is set; 2'b11 DECERR (optional feature only).
- Latency: address/data handshake at cycle 0 -> mem_valid_o at cycle 2. mem_rvalid_i at cycle N -> bvalid/rvalid at cycle N+1.
- New AXI requests may be buffered while another transaction is in any non-IDLE state.
- Back-to-back B/R back-pressure never drops or reorders a response.

Optional Feature:
AXIL_ADDR_CHECK_EN.
- Defined: an address outside [ADDR_BASE, ADDR_BASE+ADDR_SIZE) skips the memory entirely, goes straight from IDLE to WR_RESP / RD_RESP with resp 2'b11 and rdata 0, and frees its buffers.
- Undefined: every address is forwarded to the memory; 2'b11 is never produced.

Test Plan:
- Single write: AW 0x10 and W 0xDEADBEEF/strb 0xF in the same cycle, mem_ready_i=1, mem_rvalid_i 1 cycle later -> mem_we_o=1, addr 0x10, wdata 0xDEADBEEF at cycle 2; bresp 00 one cycle after mem_rvalid_i.
- W before AW: W at cycle 0, AW at cycle 3 -> no mem_valid_o before cycle 5; write completes with bresp 00 and s_wready_o=0 during cycles 1-4.
- Read with stall: AR 0x20, mem_ready_i low 3 cycles, then mem_rdata_i 0x12345678 with mem_err_i=1 -> rdata 0x12345678, rresp 10; the request is held stable across the stall.
- Arbitration: write and read pending simultaneously after reset -> write serviced first, then read; repeat -> read first, then write.
- Back-pressure: s_rready_i low for 5 cycles -> rvalid and rdata held; a new AR is accepted into the buffer and issued only after the R handshake.
- AXIL_ADDR_CHECK_EN defined, ADDR_BASE 0x1000, read 0x0FFC -> no mem_valid_o, rresp 11, rdata 0. Asserting rst_i mid-WR_WAIT -> all outputs 0 asynchronously, no bvalid.

Source files
------------

// File: rtl/axil_mem_responder.sv
// ============================================================================
// Module   : axil_mem_responder
// Purpose  : AXI4-Lite subordinate that replays one transaction at a time onto
//            a SimpleMemory-style request/response port. Optional address
//            window decode is enabled by defining AXIL_ADDR_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_mem_responder #(
   parameter int          ADDR_W    = 32,
   parameter int          DATA_W    = 32,
   parameter logic [63:0] ADDR_BASE = 64'h0,
   parameter logic [63:0] ADDR_SIZE = 64'd4096
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  s_awvalid_i,
   output logic                  s_awready_o,
   input  logic [ADDR_W-1:0]     s_awaddr_i,
   input  logic [2:0]            s_awprot_i,
   input  logic                  s_wvalid_i,
   output logic                  s_wready_o,
   input  logic [DATA_W-1:0]     s_wdata_i,
   input  logic [DATA_W/8-1:0]   s_wstrb_i,
   output logic                  s_bvalid_o,
   input  logic                  s_bready_i,
   output logic [1:0]            s_bresp_o,
   input  logic                  s_arvalid_i,
   output logic                  s_arready_o,
   input  logic [ADDR_W-1:0]     s_araddr_i,
   input  logic [2:0]            s_arprot_i,
   output logic                  s_rvalid_o,
   input  logic                  s_rready_i,
   output logic [DATA_W-1:0]     s_rdata_o,
   output logic [1:0]            s_rresp_o,
   output logic                  mem_valid_o,
   input  logic                  mem_ready_i,
   output logic                  mem_we_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic [DATA_W-1:0]     mem_wdata_o,
   output logic [DATA_W/8-1:0]   mem_wstrb_o,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_W-1:0]     mem_rdata_i,
   input  logic                  mem_err_i
);

   localparam int         c_strb_w     = DATA_W / 8;
   localparam logic [2:0] c_st_idle    = 3'd0;
   localparam logic [2:0] c_st_wr_req  = 3'd1;
   localparam logic [2:0] c_st_wr_wait = 3'd2;
   localparam logic [2:0] c_st_wr_resp = 3'd3;
   localparam logic [2:0] c_st_rd_req  = 3'd4;
   localparam logic [2:0] c_st_rd_wait = 3'd5;
   localparam logic [2:0] c_st_rd_resp = 3'd6;

   logic [2:0]          r_state;
   logic                r_run;
   logic                r_aw_full;
   logic [ADDR_W-1:0]   r_awaddr;
   logic                r_w_full;
   logic [DATA_W-1:0]   r_wdata;
   logic [c_strb_w-1:0] r_wstrb;
   logic                r_ar_full;
   logic [ADDR_W-1:0]   r_araddr;
   logic                r_prio_wr;
   logic [1:0]          r_resp;
   logic [DATA_W-1:0]   r_rdata;

   logic w_aw_acc, w_w_acc, w_ar_acc;
   logic w_wr_pend, w_rd_pend, w_grant_wr, w_grant_rd;
   logic w_wr_ok, w_rd_ok, w_free_wr, w_free_rd;
   logic w_unused_prot;

   assign w_unused_prot = &{1'b0, s_awprot_i, s_arprot_i};

`ifdef AXIL_ADDR_CHECK_EN
   assign w_wr_ok = (64'(r_awaddr) >= ADDR_BASE) && (64'(r_awaddr) < ADDR_BASE + ADDR_SIZE);
   assign w_rd_ok = (64'(r_araddr) >= ADDR_BASE) && (64'(r_araddr) < ADDR_BASE + ADDR_SIZE);
`else
   localparam logic [63:0] c_unused_win = ADDR_BASE + ADDR_SIZE;
   assign w_wr_ok = 1'b1;
   assign w_rd_ok = 1'b1;
`endif

   // Ready flags stay low while in reset and for the first cycle after it.
   assign s_awready_o = r_run & ~r_aw_full;
   assign s_wready_o  = r_run & ~r_w_full;
   assign s_arready_o = r_run & ~r_ar_full;

   assign w_aw_acc = s_awvalid_i & s_awready_o;
   assign w_w_acc  = s_wvalid_i  & s_wready_o;
   assign w_ar_acc = s_arvalid_i & s_arready_o;

   assign w_wr_pend  = r_aw_full & r_w_full;
   assign w_rd_pend  = r_ar_full;
   assign w_grant_wr = (r_state == c_st_idle) & w_wr_pend & (~w_rd_pend | r_prio_wr);
   assign w_grant_rd = (r_state == c_st_idle) & w_rd_pend & ~w_grant_wr;

   // Buffers are released on memory acceptance, or at grant when decode rejects them.
   assign w_free_wr = ((r_state == c_st_wr_req) & mem_ready_i) | (w_grant_wr & ~w_wr_ok);
   assign w_free_rd = ((r_state == c_st_rd_req) & mem_ready_i) | (w_grant_rd & ~w_rd_ok);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_run     <= 1'b0;
         r_aw_full <= 1'b0;
         r_awaddr  <= '0;
         r_w_full  <= 1'b0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_ar_full <= 1'b0;
         r_araddr  <= '0;
      end else begin
         r_run <= 1'b1;
         if (w_aw_acc) begin
            r_aw_full <= 1'b1;
            r_awaddr  <= s_awaddr_i;
         end else if (w_free_wr) begin
            r_aw_full <= 1'b0;
         end
         if (w_w_acc) begin
            r_w_full <= 1'b1;
            r_wdata  <= s_wdata_i;
            r_wstrb  <= s_wstrb_i;
         end else if (w_free_wr) begin
            r_w_full <= 1'b0;
         end
         if (w_ar_acc) begin
            r_ar_full <= 1'b1;
            r_araddr  <= s_araddr_i;
         end else if (w_free_rd) begin
            r_ar_full <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= c_st_idle;
         r_prio_wr <= 1'b1;
         r_resp    <= 2'b00;
         r_rdata   <= '0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (w_grant_wr) begin
                  r_prio_wr <= 1'b0;
                  if (w_wr_ok) begin
                     r_state <= c_st_wr_req;
                  end else begin
                     r_state <= c_st_wr_resp;
                     r_resp  <= 2'b11;
                  end
               end else if (w_grant_rd) begin
                  r_prio_wr <= 1'b1;
                  if (w_rd_ok) begin
                     r_state <= c_st_rd_req;
                  end else begin
                     r_state <= c_st_rd_resp;
                     r_resp  <= 2'b11;
                     r_rdata <= '0;
                  end
               end
            end
            c_st_wr_req:  if (mem_ready_i) r_state <= c_st_wr_wait;
            c_st_wr_wait: begin
               if (mem_rvalid_i) begin
                  r_resp  <= mem_err_i ? 2'b10 : 2'b00;
                  r_state <= c_st_wr_resp;
               end
            end
            c_st_wr_resp: if (s_bready_i) r_state <= c_st_idle;
            c_st_rd_req:  if (mem_ready_i) r_state <= c_st_rd_wait;
            c_st_rd_wait: begin
               if (mem_rvalid_i) begin
                  r_resp  <= mem_err_i ? 2'b10 : 2'b00;
                  r_rdata <= mem_rdata_i;
                  r_state <= c_st_rd_resp;
               end
            end
            c_st_rd_resp: if (s_rready_i) r_state <= c_st_idle;
            default:      r_state <= c_st_idle;
         endcase
      end
   end

   assign s_bvalid_o = (r_state == c_st_wr_resp);
   assign s_bresp_o  = r_resp;
   assign s_rvalid_o = (r_state == c_st_rd_resp);
   assign s_rresp_o  = r_resp;
   assign s_rdata_o  = r_rdata;

   // Request payload comes straight from the held buffers, zero outside request states.
   assign mem_valid_o = (r_state == c_st_wr_req) | (r_state == c_st_rd_req);
   assign mem_we_o    = (r_state == c_st_wr_req);
   assign mem_addr_o  = (r_state == c_st_wr_req) ? r_awaddr :
                        (r_state == c_st_rd_req) ? r_araddr : '0;
   assign mem_wdata_o = (r_state == c_st_wr_req) ? r_wdata : '0;
   assign mem_wstrb_o = (r_state == c_st_wr_req) ? r_wstrb : '0;

endmodule

`default_nettype wire

// File: tb/tb_axil_mem_responder.sv
// ============================================================================
// Module   : tb_axil_mem_responder
// Purpose  : Directed self-checking bench for axil_mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axil_mem_responder;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        s_awvalid_i = 1'b0, s_awready_o;
   logic [31:0] s_awaddr_i = '0;
   logic [2:0]  s_awprot_i = '0;
   logic        s_wvalid_i = 1'b0, s_wready_o;
   logic [31:0] s_wdata_i = '0;
   logic [3:0]  s_wstrb_i = '0;
   logic        s_bvalid_o, s_bready_i = 1'b0;
   logic [1:0]  s_bresp_o;
   logic        s_arvalid_i = 1'b0, s_arready_o;
   logic [31:0] s_araddr_i = '0;
   logic [2:0]  s_arprot_i = '0;
   logic        s_rvalid_o, s_rready_i = 1'b0;
   logic [31:0] s_rdata_o;
   logic [1:0]  s_rresp_o;
   logic        mem_valid_o, mem_ready_i = 1'b0, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_wstrb_o;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        mem_err_i = 1'b0;

   int total = 0;
   int bad   = 0;

   axil_mem_responder #(
      .ADDR_W(32), .DATA_W(32), .ADDR_BASE(64'h1000), .ADDR_SIZE(64'h1000)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o), .s_awaddr_i(s_awaddr_i),
      .s_awprot_i(s_awprot_i),
      .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o), .s_wdata_i(s_wdata_i),
      .s_wstrb_i(s_wstrb_i),
      .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i), .s_bresp_o(s_bresp_o),
      .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o), .s_araddr_i(s_araddr_i),
      .s_arprot_i(s_arprot_i),
      .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i), .s_rdata_o(s_rdata_o),
      .s_rresp_o(s_rresp_o),
      .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
      tick();
      tick();
   endtask

   // Waits for a request, optionally stalls it, accepts it, then returns one response pulse.
   task automatic mem_serve(input int stall, input logic [31:0] rd, input logic err,
                            output logic we, output logic [31:0] addr);
      int n = 0;
      while (mem_valid_o !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("req_seen", mem_valid_o, 1);
      we   = mem_we_o;
      addr = mem_addr_o;
      for (int i = 0; i < stall; i++) begin
         tick();
         chk("stall_valid", mem_valid_o, 1);
         chk("stall_addr", mem_addr_o, addr);
      end
      mem_ready_i = 1'b1;
      tick();
      mem_ready_i = 1'b0;
      chk("post_accept_valid", mem_valid_o, 0);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rd;
      mem_err_i    = err;
      tick();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      mem_err_i    = 1'b0;
   endtask

   initial begin
      logic        we;
      logic [31:0] a;
      logic        saw;

      // Reset state
      #2;
      chk("rst_awready", s_awready_o, 0);
      chk("rst_memvalid", mem_valid_o, 0);
      chk("rst_bvalid", s_bvalid_o, 0);
      chk("rst_rdata", s_rdata_o, 0);
      tick();
      rst_i = 1'b0;
      tick();
      tick();

      // Single write, AW and W together
      s_awvalid_i = 1; s_awaddr_i = 32'h1010;
      s_wvalid_i = 1; s_wdata_i = 32'hDEADBEEF; s_wstrb_i = 4'hF;
      chk("t1_awready", s_awready_o, 1);
      chk("t1_wready", s_wready_o, 1);
      tick();
      s_awvalid_i = 0; s_wvalid_i = 0;
      chk("t1_c1_valid", mem_valid_o, 0);
      chk("t1_c1_awready", s_awready_o, 0);
      tick();
      chk("t1_c2_valid", mem_valid_o, 1);
      chk("t1_c2_we", mem_we_o, 1);
      chk("t1_c2_addr", mem_addr_o, 32'h1010);
      chk("t1_c2_wdata", mem_wdata_o, 32'hDEADBEEF);
      chk("t1_c2_wstrb", mem_wstrb_o, 4'hF);
      mem_ready_i = 1;
      tick();
      mem_ready_i = 0;
      chk("t1_c3_valid", mem_valid_o, 0);
      chk("t1_c3_awready", s_awready_o, 1);
      chk("t1_c3_bvalid", s_bvalid_o, 0);
      mem_rvalid_i = 1;
      tick();
      mem_rvalid_i = 0;
      chk("t1_bvalid", s_bvalid_o, 1);
      chk("t1_bresp", s_bresp_o, 2'b00);
      s_bready_i = 1;
      tick();
      s_bready_i = 0;
      chk("t1_bvalid_done", s_bvalid_o, 0);

      // W before AW
      s_wvalid_i = 1; s_wdata_i = 32'hCAFEF00D; s_wstrb_i = 4'h3;
      tick();
      s_wvalid_i = 0;
      for (int c = 1; c <= 4; c++) begin
         chk("t2_wready_low", s_wready_o, 0);
         chk("t2_no_req", mem_valid_o, 0);
         if (c == 3) begin
            s_awvalid_i = 1; s_awaddr_i = 32'h1014;
         end
         tick();
         s_awvalid_i = 0;
      end
      chk("t2_c5_valid", mem_valid_o, 1);
      chk("t2_c5_addr", mem_addr_o, 32'h1014);
      chk("t2_c5_wdata", mem_wdata_o, 32'hCAFEF00D);
      chk("t2_c5_wstrb", mem_wstrb_o, 4'h3);
      mem_serve(0, 32'h0, 1'b0, we, a);
      chk("t2_bvalid", s_bvalid_o, 1);
      chk("t2_bresp", s_bresp_o, 2'b00);
      s_bready_i = 1; tick(); s_bready_i = 0;

      // Read with request stall and error response
      s_arvalid_i = 1; s_araddr_i = 32'h1020;
      tick();
      s_arvalid_i = 0;
      tick();
      chk("t3_valid", mem_valid_o, 1);
      chk("t3_we", mem_we_o, 0);
      chk("t3_addr", mem_addr_o, 32'h1020);
      chk("t3_wstrb", mem_wstrb_o, 4'h0);
      mem_serve(3, 32'h12345678, 1'b1, we, a);
      chk("t3_rvalid", s_rvalid_o, 1);
      chk("t3_rdata", s_rdata_o, 32'h12345678);
      chk("t3_rresp", s_rresp_o, 2'b10);
      s_rready_i = 1; tick(); s_rready_i = 0;
      chk("t3_rvalid_done", s_rvalid_o, 0);

      // Arbitration: write first after reset, then alternation
      do_reset();
      s_bready_i = 1; s_rready_i = 1;
      s_awvalid_i = 1; s_awaddr_i = 32'h1030; s_wvalid_i = 1; s_wdata_i = 32'h11111111;
      s_wstrb_i = 4'hF; s_arvalid_i = 1; s_araddr_i = 32'h1040;
      tick();
      s_awvalid_i = 0; s_wvalid_i = 0; s_arvalid_i = 0;
      mem_serve(0, 32'h0, 1'b0, we, a);
      chk("arb1_first_we", we, 1);
      chk("arb1_first_addr", a, 32'h1030);
      chk("arb1_bvalid", s_bvalid_o, 1);
      tick();
      mem_serve(0, 32'h0BADF00D, 1'b0, we, a);
      chk("arb1_second_we", we, 0);
      chk("arb1_second_addr", a, 32'h1040);
      chk("arb1_rdata", s_rdata_o, 32'h0BADF00D);
      tick();
      s_awvalid_i = 1; s_awaddr_i = 32'h1050; s_wvalid_i = 1;
      tick();
      s_awvalid_i = 0; s_wvalid_i = 0;
      mem_serve(0, 32'h0, 1'b0, we, a);
      chk("arb_solo_we", we, 1);
      tick();
      s_awvalid_i = 1; s_awaddr_i = 32'h1060; s_wvalid_i = 1;
      s_arvalid_i = 1; s_araddr_i = 32'h1070;
      tick();
      s_awvalid_i = 0; s_wvalid_i = 0; s_arvalid_i = 0;
      mem_serve(0, 32'h0, 1'b0, we, a);
      chk("arb2_first_we", we, 0);
      chk("arb2_first_addr", a, 32'h1070);
      tick();
      mem_serve(0, 32'h0, 1'b0, we, a);
      chk("arb2_second_we", we, 1);
      chk("arb2_second_addr", a, 32'h1060);
      tick();
      s_bready_i = 0; s_rready_i = 0;

      // R back-pressure with a second read queued
      s_arvalid_i = 1; s_araddr_i = 32'h1080;
      tick();
      s_arvalid_i = 0;
      mem_serve(0, 32'hA5A5A5A5, 1'b0, we, a);
      chk("t5_rvalid", s_rvalid_o, 1);
      chk("t5_arready_free", s_arready_o, 1);
      s_arvalid_i = 1; s_araddr_i = 32'h1084;
      tick();
      s_arvalid_i = 0;
      chk("t5_arready_full", s_arready_o, 0);
      for (int i = 0; i < 5; i++) begin
         chk("t5_hold_rvalid", s_rvalid_o, 1);
         chk("t5_hold_rdata", s_rdata_o, 32'hA5A5A5A5);
         chk("t5_hold_noreq", mem_valid_o, 0);
         tick();
      end
      s_rready_i = 1;
      tick();
      s_rready_i = 0;
      chk("t5_rvalid_done", s_rvalid_o, 0);
      chk("t5_idle_noreq", mem_valid_o, 0);
      tick();
      chk("t5_next_valid", mem_valid_o, 1);
      chk("t5_next_addr", mem_addr_o, 32'h1084);
      mem_serve(0, 32'h5A5A5A5A, 1'b0, we, a);
      chk("t5_next_rdata", s_rdata_o, 32'h5A5A5A5A);
      s_rready_i = 1; tick(); s_rready_i = 0;

`ifdef AXIL_ADDR_CHECK_EN
      // Out-of-window read is answered locally with DECERR
      s_arvalid_i = 1; s_araddr_i = 32'h0FFC;
      tick();
      s_arvalid_i = 0;
      saw = 1'b0;
      for (int i = 0; i < 10 && s_rvalid_o !== 1'b1; i++) begin
         saw = saw | mem_valid_o;
         tick();
      end
      chk("t6_no_mem_req", saw, 0);
      chk("t6_rvalid", s_rvalid_o, 1);
      chk("t6_rresp", s_rresp_o, 2'b11);
      chk("t6_rdata", s_rdata_o, 32'h0);
      s_rready_i = 1; tick(); s_rready_i = 0;
`else
      saw = 1'b0;
`endif

      // Reset asserted while waiting for the write response
      s_awvalid_i = 1; s_awaddr_i = 32'h1090; s_wvalid_i = 1; s_wdata_i = 32'h77777777;
      tick();
      s_awvalid_i = 0; s_wvalid_i = 0;
      for (int i = 0; i < 10 && mem_valid_o !== 1'b1; i++) tick();
      chk("t7_req", mem_valid_o, 1);
      mem_ready_i = 1;
      tick();
      mem_ready_i = 0;
      #2 rst_i = 1;
      #1;
      chk("t7_rst_memvalid", mem_valid_o, 0);
      chk("t7_rst_awready", s_awready_o, 0);
      chk("t7_rst_wready", s_wready_o, 0);
      chk("t7_rst_arready", s_arready_o, 0);
      chk("t7_rst_bvalid", s_bvalid_o, 0);
      chk("t7_rst_rdata", s_rdata_o, 0);
      chk("t7_rst_addr", mem_addr_o, 0);
      tick();
      rst_i = 0;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("t7_no_bvalid", s_bvalid_o, 0);
         tick();
      end
      chk("t7_awready_back", s_awready_o, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
